// File: rtl/imm_gen_if.sv
// Handshake and data bundle for the immediate-generator stage.
// slave  : the stage itself (consumes instructions, produces immediates)
// master : the environment around it (decode control upstream, execute downstream)
interface imm_gen_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        in_imm_i;
   logic        in_imm_s;
   logic        in_imm_sb;
   logic        in_imm_u;
   logic        in_imm_uj;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_imm;
   logic [2:0]  out_type;

   modport slave (
      input  in_valid, in_instr, in_imm_i, in_imm_s, in_imm_sb, in_imm_u, in_imm_uj,
      input  flush, out_ready,
      output in_ready, out_valid, out_instr, out_imm, out_type
   );

   modport master (
      output in_valid, in_instr, in_imm_i, in_imm_s, in_imm_sb, in_imm_u, in_imm_uj,
      output flush, out_ready,
      input  in_ready, out_valid, out_instr, out_imm, out_type
   );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RV32I immediate generator with a two-entry (main + skid)
// output buffer. The immediate is assembled combinationally from the
// incoming instruction; only the finished instr/imm/type triple is stored.
// in_ready comes straight from a flop so out_ready never reaches it
// combinationally.
module imm_gen_stage (
   input  logic     clk,
   input  logic     rst_n,
   imm_gen_if.slave bus
);
   localparam logic [2:0] T_NONE = 3'd0;
   localparam logic [2:0] T_I    = 3'd1;
   localparam logic [2:0] T_S    = 3'd2;
   localparam logic [2:0] T_SB   = 3'd3;
   localparam logic [2:0] T_U    = 3'd4;
   localparam logic [2:0] T_UJ   = 3'd5;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic [31:0] main_instr_q, main_instr_d;
   logic [31:0] main_imm_q, main_imm_d;
   logic [2:0]  main_type_q, main_type_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_imm_q, skid_imm_d;
   logic [2:0]  skid_type_q, skid_type_d;
   logic [31:0] asm_imm;
   logic [2:0]  asm_type;
   logic        accept;
   logic        drain;

   // Selects are not one-hot (AUIPC raises both I and U): fixed priority.
   function automatic logic [2:0] resolve_type(input logic i, input logic s, input logic sb,
                                               input logic u, input logic uj);
      logic [2:0] t;
      t = T_NONE;
      if (uj)      t = T_UJ;
      else if (u)  t = T_U;
      else if (sb) t = T_SB;
      else if (s)  t = T_S;
      else if (i)  t = T_I;
      return t;
   endfunction

   function automatic logic [31:0] build_imm(input logic [31:0] ins, input logic [2:0] t);
      logic [31:0] r;
      case (t)
         T_I:     r = {{20{ins[31]}}, ins[31:20]};
         T_S:     r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         T_SB:    r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         T_U:     r = {ins[31:12], 12'b0};
         T_UJ:    r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Flush discards the same-cycle input; drain only means something when main holds data.
   assign accept = bus.in_valid && in_ready_q && !bus.flush;
   assign drain  = (state_q != EMPTY) && bus.out_ready;

   // Assemble the immediate for the instruction currently offered.
   always_comb begin
      asm_type = resolve_type(bus.in_imm_i, bus.in_imm_s, bus.in_imm_sb,
                              bus.in_imm_u, bus.in_imm_uj);
      asm_imm  = build_imm(bus.in_instr, asm_type);
   end

   // Buffer next-state and entry movement; flush overrides everything.
   always_comb begin
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_imm_d   = main_imm_q;
      main_type_d  = main_type_q;
      skid_instr_d = skid_instr_q;
      skid_imm_d   = skid_imm_q;
      skid_type_d  = skid_type_q;
      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_instr_d = bus.in_instr;
                  main_imm_d   = asm_imm;
                  main_type_d  = asm_type;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_instr_d = bus.in_instr;
                  main_imm_d   = asm_imm;
                  main_type_d  = asm_type;
               end else if (drain) begin
                  state_d = EMPTY;
               end else if (accept) begin
                  skid_instr_d = bus.in_instr;
                  skid_imm_d   = asm_imm;
                  skid_type_d  = asm_type;
                  state_d      = FULL;
               end
            end
            FULL: begin
               if (drain) begin
                  main_instr_d = skid_instr_q;
                  main_imm_d   = skid_imm_q;
                  main_type_d  = skid_type_q;
                  state_d      = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d = (state_d != FULL);
   end

   // State, ready and entry registers; reset leaves an empty, zeroed buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         in_ready_q   <= 1'b1;
         main_instr_q <= 32'd0;
         main_imm_q   <= 32'd0;
         main_type_q  <= T_NONE;
         skid_instr_q <= 32'd0;
         skid_imm_q   <= 32'd0;
         skid_type_q  <= T_NONE;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         main_instr_q <= main_instr_d;
         main_imm_q   <= main_imm_d;
         main_type_q  <= main_type_d;
         skid_instr_q <= skid_instr_d;
         skid_imm_q   <= skid_imm_d;
         skid_type_q  <= skid_type_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.out_instr = main_instr_q;
   assign bus.out_imm   = main_imm_q;
   assign bus.out_type  = main_type_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed + random bench for imm_gen_stage with a scoreboard queue.
module tb_imm_gen_stage;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [2:0]  typ;
   } exp_t;

   logic clk;
   logic rst_n;
   imm_gen_if bus ();

   imm_gen_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   exp_t cur_exp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference immediate built with arithmetic shifts of a left-aligned field.
   function automatic logic [2:0] ref_type(input logic [4:0] sel);
      // sel = {i, s, sb, u, uj}
      if (sel[0])      return 3'd5;
      else if (sel[1]) return 3'd4;
      else if (sel[2]) return 3'd3;
      else if (sel[3]) return 3'd2;
      else if (sel[4]) return 3'd1;
      return 3'd0;
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] t);
      logic signed [31:0] w;
      w = 32'sd0;
      case (t)
         3'd1: w = $signed(i) >>> 20;
         3'd2: w = $signed({i[31:25], i[11:7], 20'b0}) >>> 20;
         3'd3: w = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}) >>> 19;
         3'd4: w = $signed({i[31:12], 12'b0});
         3'd5: w = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}) >>> 11;
         default: w = 32'sd0;
      endcase
      return w;
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic [4:0] sel,
                        input logic [31:0] eimm, input logic [2:0] etyp, input logic ordy);
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.in_imm_i  = sel[4];
      bus.in_imm_s  = sel[3];
      bus.in_imm_sb = sel[2];
      bus.in_imm_u  = sel[1];
      bus.in_imm_uj = sel[0];
      bus.out_ready = ordy;
      cur_exp = '{instr: ins, imm: eimm, typ: etyp};
   endtask

   task automatic drive_rand(input logic v, input logic ordy);
      logic [31:0] ins;
      logic [4:0]  sel;
      logic [2:0]  t;
      ins = $urandom;
      sel = 5'($urandom_range(0, 31));
      t   = ref_type(sel);
      drive(v, ins, sel, ref_imm(ins, t), t, ordy);
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 32'd0, 5'd0, 32'd0, 3'd0, ordy);
   endtask

   // Evaluate this cycle's transfers, then advance to the next falling edge.
   task automatic tick();
      exp_t e;
      #1;
      if (bus.flush) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("out_instr", bus.out_instr, e.instr);
               check("out_imm", bus.out_imm, e.imm);
               check("out_type", {29'd0, bus.out_type}, {29'd0, e.typ});
            end
         end
         if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      idle(1'b1);
      while (sb.size() > 0 && n < 20) begin
         tick();
         n++;
      end
      check("drain_complete", sb.size(), 0);
      check("drain_out_valid", {31'd0, bus.out_valid}, 0);
   endtask

   initial begin
      bus.flush = 1'b0;
      idle(1'b0);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'd0, bus.out_valid}, 0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 1);
      check("rst_out_imm", bus.out_imm, 0);
      check("rst_out_instr", bus.out_instr, 0);
      check("rst_out_type", {29'd0, bus.out_type}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ADDI: one cycle latency
      drive(1'b1, 32'hFFF00093, 5'b10000, 32'hFFFFFFFF, 3'd1, 1'b1);
      tick();
      check("addi_latency_valid", {31'd0, bus.out_valid}, 1);
      idle(1'b1);
      tick();

      // AUIPC: I and U both raised, U wins
      drive(1'b1, 32'h00001017, 5'b10010, 32'h00001000, 3'd4, 1'b1);
      tick();
      drain();

      // Back-to-back, no bubbles
      drive(1'b1, 32'hFE000EE3, 5'b00100, 32'hFFFFFFFC, 3'd3, 1'b1);
      tick();
      check("b2b_valid0", {31'd0, bus.out_valid}, 1);
      drive(1'b1, 32'hFE20AC23, 5'b01000, 32'hFFFFFFF8, 3'd2, 1'b1);
      tick();
      check("b2b_valid1", {31'd0, bus.out_valid}, 1);
      check("b2b_ready1", {31'd0, bus.in_ready}, 1);
      drive(1'b1, 32'h0080006F, 5'b00001, 32'h00000008, 3'd5, 1'b1);
      tick();
      check("b2b_valid2", {31'd0, bus.out_valid}, 1);
      drive(1'b1, 32'h12345037, 5'b00010, 32'h12345000, 3'd4, 1'b1);
      tick();
      check("b2b_valid3", {31'd0, bus.out_valid}, 1);
      check("b2b_ready3", {31'd0, bus.in_ready}, 1);
      drain();

      // Backpressure: three offered, two taken
      drive_rand(1'b1, 1'b0);
      tick();
      check("bp_ready_one", {31'd0, bus.in_ready}, 1);
      drive_rand(1'b1, 1'b0);
      tick();
      check("bp_ready_full", {31'd0, bus.in_ready}, 0);
      drive_rand(1'b1, 1'b0);
      tick();
      check("bp_ready_held", {31'd0, bus.in_ready}, 0);
      check("bp_queue_two", sb.size(), 2);
      idle(1'b1);
      tick();
      check("bp_ready_rise", {31'd0, bus.in_ready}, 1);
      drain();

      // Flush while FULL with an instruction on the input
      drive_rand(1'b1, 1'b0);
      tick();
      drive_rand(1'b1, 1'b0);
      tick();
      check("fl_full", {31'd0, bus.in_ready}, 0);
      drive_rand(1'b1, 1'b0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("fl_out_valid", {31'd0, bus.out_valid}, 0);
      check("fl_in_ready", {31'd0, bus.in_ready}, 1);
      idle(1'b1);
      for (int k = 0; k < 3; k++) tick();
      check("fl_nothing_emitted", {31'd0, bus.out_valid}, 0);

      // Asynchronous reset between edges
      drive_rand(1'b1, 1'b0);
      tick();
      drive_rand(1'b1, 1'b0);
      tick();
      idle(1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, bus.out_valid}, 0);
      check("arst_out_imm", bus.out_imm, 0);
      check("arst_out_instr", bus.out_instr, 0);
      check("arst_out_type", {29'd0, bus.out_type}, 0);
      check("arst_in_ready", {31'd0, bus.in_ready}, 1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_stays_empty", {31'd0, bus.out_valid}, 0);
      drive(1'b1, 32'h00C00513, 5'b10000, 32'h0000000C, 3'd1, 1'b1);
      tick();
      check("arst_new_latency", {31'd0, bus.out_valid}, 1);
      drain();

      // Random stream with random backpressure
      for (int k = 0; k < 40; k++) begin
         drive_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
         tick();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
